// File: rtl/wb_stage.sv
// Write-back stage: retires instructions into the register-file write port, issuing and
// extracting data-memory loads. Optional misaligned-load trap under WB_MISALIGN_TRAP_EN.
module wb_stage #(
    parameter int WORD_SIZE = 32,
    parameter int NUM_REGS  = 32,
    parameter int REG_SEL   = $clog2(NUM_REGS),
    parameter int ADDR_SIZE = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_write_reg,
    input  logic                 in_mem_read,
    input  logic [2:0]           in_func3,
    input  logic [REG_SEL-1:0]   in_dest,
    input  logic [WORD_SIZE-1:0] in_alu_result,
    output logic                 dmem_req,
    output logic [ADDR_SIZE-1:0] dmem_addr,
    input  logic [WORD_SIZE-1:0] dmem_rdata,
    input  logic                 dmem_rvalid,
    output logic                 reg_write,
    output logic [REG_SEL-1:0]   rd_select,
    output logic [WORD_SIZE-1:0] rd_data,
`ifdef WB_MISALIGN_TRAP_EN
    output logic                 misalign,
`endif
    output logic                 busy
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        LOAD_WAIT = 1'b1
    } state_t;

    state_t                 state_r, state_next_s;
    logic                   reg_write_r, reg_write_next_s;
    logic [REG_SEL-1:0]     rd_select_r, rd_select_next_s;
    logic [WORD_SIZE-1:0]   rd_data_r, rd_data_next_s;
    logic                   dmem_req_r, dmem_req_next_s;
    logic [ADDR_SIZE-1:0]   dmem_addr_r, dmem_addr_next_s;
    logic [2:0]             func3_r, func3_next_s;
    logic [REG_SEL-1:0]     dest_r, dest_next_s;
    logic                   write_r, write_next_s;
    logic [1:0]             lane_r, lane_next_s;
    logic                   misalign_r, misalign_next_s;
    logic                   load_bad_s;

    // Byte/half select and sign/zero extension of a returned load word.
    function automatic logic [WORD_SIZE-1:0] extract_load(
        input logic [2:0]           f3,
        input logic [1:0]           lane,
        input logic [WORD_SIZE-1:0] word
    );
        logic [7:0]           byte_v;
        logic [15:0]          half_v;
        logic [WORD_SIZE-1:0] res_v;
        case (lane)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        if (lane[1]) begin
            half_v = word[31:16];
        end else begin
            half_v = word[15:0];
        end
        case (f3)
            3'b000:  res_v = {{(WORD_SIZE-8){byte_v[7]}}, byte_v};
            3'b100:  res_v = {{(WORD_SIZE-8){1'b0}}, byte_v};
            3'b001:  res_v = {{(WORD_SIZE-16){half_v[15]}}, half_v};
            3'b101:  res_v = {{(WORD_SIZE-16){1'b0}}, half_v};
            default: res_v = word;
        endcase
        return res_v;
    endfunction

`ifdef WB_MISALIGN_TRAP_EN
    // Halfword loads need addr[0]==0; LW needs a word-aligned address.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        logic bad_v;
        case (f3)
            3'b001, 3'b101: bad_v = lo[0];
            3'b010:         bad_v = (lo != 2'b00);
            default:        bad_v = 1'b0;
        endcase
        return bad_v;
    endfunction

    // Misalignment detection for the instruction presented this cycle.
    always_comb begin
        load_bad_s = is_misaligned(in_func3, in_alu_result[1:0]);
    end
`else
    // Without the trap every load proceeds.
    always_comb begin
        load_bad_s = 1'b0;
    end
`endif

    assign in_ready  = (state_r == IDLE);
    assign busy      = (state_r == LOAD_WAIT);
    assign reg_write = reg_write_r;
    assign rd_select = rd_select_r;
    assign rd_data   = rd_data_r;
    assign dmem_req  = dmem_req_r;
    assign dmem_addr = dmem_addr_r;
`ifdef WB_MISALIGN_TRAP_EN
    assign misalign  = misalign_r;
`endif

    // Next-state and next-output logic; pulses default low, data fields hold.
    always_comb begin
        state_next_s     = state_r;
        reg_write_next_s = 1'b0;
        rd_select_next_s = rd_select_r;
        rd_data_next_s   = rd_data_r;
        dmem_req_next_s  = 1'b0;
        dmem_addr_next_s = dmem_addr_r;
        func3_next_s     = func3_r;
        dest_next_s      = dest_r;
        write_next_s     = write_r;
        lane_next_s      = lane_r;
        misalign_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (in_mem_read) begin
                        if (load_bad_s) begin
                            misalign_next_s = 1'b1;
                        end else begin
                            func3_next_s     = in_func3;
                            dest_next_s      = in_dest;
                            write_next_s     = in_write_reg;
                            lane_next_s      = in_alu_result[1:0];
                            dmem_req_next_s  = 1'b1;
                            dmem_addr_next_s = in_alu_result[ADDR_SIZE+1:2];
                            state_next_s     = LOAD_WAIT;
                        end
                    end else if (in_write_reg && (in_dest != {REG_SEL{1'b0}})) begin
                        reg_write_next_s = 1'b1;
                        rd_select_next_s = in_dest;
                        rd_data_next_s   = in_alu_result;
                    end else begin
                        reg_write_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                if (dmem_rvalid) begin
                    state_next_s = IDLE;
                    // x0 is never written, even by a load.
                    if (write_r && (dest_r != {REG_SEL{1'b0}})) begin
                        reg_write_next_s = 1'b1;
                        rd_select_next_s = dest_r;
                        rd_data_next_s   = extract_load(func3_r, lane_r, dmem_rdata);
                    end else begin
                        reg_write_next_s = 1'b0;
                    end
                end else begin
                    state_next_s = LOAD_WAIT;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            reg_write_r <= 1'b0;
            rd_select_r <= {REG_SEL{1'b0}};
            rd_data_r   <= {WORD_SIZE{1'b0}};
            dmem_req_r  <= 1'b0;
            dmem_addr_r <= {ADDR_SIZE{1'b0}};
            func3_r     <= 3'b000;
            dest_r      <= {REG_SEL{1'b0}};
            write_r     <= 1'b0;
            lane_r      <= 2'b00;
            misalign_r  <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            reg_write_r <= reg_write_next_s;
            rd_select_r <= rd_select_next_s;
            rd_data_r   <= rd_data_next_s;
            dmem_req_r  <= dmem_req_next_s;
            dmem_addr_r <= dmem_addr_next_s;
            func3_r     <= func3_next_s;
            dest_r      <= dest_next_s;
            write_r     <= write_next_s;
            lane_r      <= lane_next_s;
            misalign_r  <= misalign_next_s;
        end
    end

`ifndef WB_MISALIGN_TRAP_EN
    logic unused_misalign_s;
    assign unused_misalign_s = misalign_r;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: a per-cycle expectation table filled by directed
// stimulus tasks from the stage's timing rules, compared every cycle at the falling edge.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_write_reg;
    logic        in_mem_read;
    logic [2:0]  in_func3;
    logic [4:0]  in_dest;
    logic [31:0] in_alu_result;
    logic        dmem_req;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        reg_write;
    logic [4:0]  rd_select;
    logic [31:0] rd_data;
    logic        busy;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    wb_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_write_reg(in_write_reg), .in_mem_read(in_mem_read),
        .in_func3(in_func3), .in_dest(in_dest), .in_alu_result(in_alu_result),
        .dmem_req(dmem_req), .dmem_addr(dmem_addr),
        .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
        .reg_write(reg_write), .rd_select(rd_select), .rd_data(rd_data),
`ifdef WB_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Expectation table indexed by cycle number (cycle c = interval after edge c).
    bit          exp_wr    [0:1023];
    bit          exp_req   [0:1023];
    bit          exp_stall [0:1023];
    bit          exp_clr   [0:1023];
    bit          exp_mis   [0:1023];
    logic [4:0]  exp_sel   [0:1023];
    logic [31:0] exp_dat   [0:1023];
    logic [9:0]  exp_adr   [0:1023];
    logic [4:0]  h_sel = 5'd0;
    logic [31:0] h_dat = 32'd0;
    logic [9:0]  h_adr = 10'd0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, expv);
        end
    endtask

    // Reference load result from plain shifts and two's-complement arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
        logic [31:0] v;
        logic [1:0]  lo;
        lo = addr[1:0];
        case (f3)
            3'b000, 3'b100: begin
                v = (word >> (32'd8 * lo)) & 32'h0000_00FF;
                if (f3 == 3'b000 && v >= 32'd128) v = v - 32'd256;
            end
            3'b001, 3'b101: begin
                v = (word >> (32'd16 * lo[1])) & 32'h0000_FFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic bit model_mis(input logic [2:0] f3, input logic [31:0] addr);
`ifdef WB_MISALIGN_TRAP_EN
        logic [1:0] lo;
        lo = addr[1:0];
        return ((f3 == 3'b001 || f3 == 3'b101) && lo[0] == 1'b1) ||
               (f3 == 3'b010 && lo != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Per-cycle comparison of every output against the expectation table.
    always @(negedge clk) begin
        if (chk_en) begin
            if (exp_clr[cyc]) begin
                h_sel = 5'd0; h_dat = 32'd0; h_adr = 10'd0;
            end
            if (exp_wr[cyc]) begin
                h_sel = exp_sel[cyc]; h_dat = exp_dat[cyc];
            end
            if (exp_req[cyc]) h_adr = exp_adr[cyc];
            check("reg_write", {31'd0, reg_write}, {31'd0, exp_wr[cyc]});
            check("in_ready",  {31'd0, in_ready},  {31'd0, ~exp_stall[cyc]});
            check("busy",      {31'd0, busy},      {31'd0, exp_stall[cyc]});
            check("dmem_req",  {31'd0, dmem_req},  {31'd0, exp_req[cyc]});
            check("dmem_addr", {22'd0, dmem_addr}, {22'd0, h_adr});
            check("rd_select", {27'd0, rd_select}, {27'd0, h_sel});
            check("rd_data",   rd_data,            h_dat);
`ifdef WB_MISALIGN_TRAP_EN
            check("misalign",  {31'd0, misalign},  {31'd0, exp_mis[cyc]});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic [4:0] dest, input logic wr, input logic [31:0] val);
        int c;
        c = cyc;
        in_valid = 1'b1; in_mem_read = 1'b0; in_write_reg = wr;
        in_dest = dest; in_alu_result = val; in_func3 = 3'b000;
        if (wr && dest != 5'd0) begin
            exp_wr[c+1] = 1'b1; exp_sel[c+1] = dest; exp_dat[c+1] = val;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] word,
                        input int wt, input logic [4:0] dest, input logic wr, input bit decoy);
        int c;
        c = cyc;
        in_valid = 1'b1; in_mem_read = 1'b1; in_write_reg = wr;
        in_dest = dest; in_alu_result = addr; in_func3 = f3;
        if (model_mis(f3, addr)) begin
            exp_mis[c+1] = 1'b1;
            step();
            in_valid = 1'b0;
        end else begin
            exp_req[c+1] = 1'b1;
            exp_adr[c+1] = addr[11:2];
            for (int k = 1; k <= wt + 1; k++) exp_stall[c+k] = 1'b1;
            if (wr && dest != 5'd0) begin
                exp_wr[c+wt+2] = 1'b1; exp_sel[c+wt+2] = dest;
                exp_dat[c+wt+2] = ref_load(f3, addr, word);
            end
            step();
            if (decoy) begin
                in_valid = 1'b1; in_mem_read = 1'b0; in_write_reg = 1'b1;
                in_dest = 5'd9; in_alu_result = 32'hDEAD_BEEF;
            end else begin
                in_valid = 1'b0;
            end
            repeat (wt) step();
            dmem_rvalid = 1'b1; dmem_rdata = word;
            step();
            dmem_rvalid = 1'b0; dmem_rdata = 32'h5A5A_5A5A; in_valid = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        rst = 1'b0; in_valid = 1'b0; in_write_reg = 1'b0; in_mem_read = 1'b0;
        in_func3 = 3'b000; in_dest = 5'd0; in_alu_result = 32'd0;
        dmem_rdata = 32'd0; dmem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1'b1;

        // Model pins from hand-computed values.
        check("pin_lb",  ref_load(3'b000, 32'h103, 32'h80FF_7F01), 32'hFFFF_FF80);
        check("pin_lbu", ref_load(3'b100, 32'h103, 32'h80FF_7F01), 32'h0000_0080);
        check("pin_lh",  ref_load(3'b001, 32'h102, 32'h8001_0000), 32'hFFFF_8001);
        check("pin_lhu", ref_load(3'b101, 32'h102, 32'h8001_0000), 32'h0000_8001);
        check("pin_lbl", ref_load(3'b000, 32'h101, 32'h80FF_7F01), 32'h0000_007F);

        step();
        alu(5'd5, 1'b1, 32'h1234_5678);
        @(negedge clk);
        check("lit_alu_wr",  {31'd0, reg_write}, 32'd1);
        check("lit_alu_sel", {27'd0, rd_select}, 32'd5);
        check("lit_alu_dat", rd_data, 32'h1234_5678);
        step();
        alu(5'd0, 1'b1, 32'h1234_5678);
        alu(5'd1, 1'b1, 32'h0000_0011);
        alu(5'd2, 1'b1, 32'h0000_0022);
        alu(5'd3, 1'b1, 32'h0000_0033);
        alu(5'd7, 1'b0, 32'hFFFF_0000);
        step();

        load(3'b000, 32'h0000_0103, 32'h80FF_7F01, 3, 5'd6, 1'b1, 1'b1);
        @(negedge clk);
        check("lit_lb_dat", rd_data, 32'hFFFF_FF80);
        step();
        load(3'b100, 32'h0000_0103, 32'h80FF_7F01, 3, 5'd7, 1'b1, 1'b0);
        load(3'b001, 32'h0000_0102, 32'h8001_0000, 1, 5'd8, 1'b1, 1'b0);
        load(3'b101, 32'h0000_0102, 32'h8001_0000, 2, 5'd9, 1'b1, 1'b1);
        load(3'b010, 32'h0000_0100, 32'hCAFE_F00D, 0, 5'd10, 1'b1, 1'b0);
        load(3'b000, 32'h0000_0201, 32'h1234_7F56, 0, 5'd12, 1'b1, 1'b0);
        load(3'b110, 32'h0000_0FFC, 32'h0BAD_C0DE, 1, 5'd13, 1'b1, 1'b0);
        load(3'b010, 32'h0000_0104, 32'h7777_7777, 0, 5'd0, 1'b1, 1'b0);
        load(3'b010, 32'h0000_0108, 32'h6666_6666, 1, 5'd14, 1'b0, 1'b0);
        alu(5'd15, 1'b1, 32'hA5A5_0001);

        // Reset while the load is outstanding; the late response must be ignored.
        c = cyc;
        in_valid = 1'b1; in_mem_read = 1'b1; in_write_reg = 1'b1;
        in_dest = 5'd16; in_alu_result = 32'h0000_0110; in_func3 = 3'b010;
        exp_req[c+1] = 1'b1; exp_adr[c+1] = 10'h044; exp_stall[c+1] = 1'b1;
        exp_clr[c+2] = 1'b1;
        step();
        in_valid = 1'b0; rst = 1'b0;
        step();
        rst = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
        step();
        dmem_rvalid = 1'b0;
        step();

        load(3'b010, 32'h0000_0101, 32'h89AB_CDEF, 1, 5'd11, 1'b1, 1'b0);
        load(3'b001, 32'h0000_0103, 32'h4321_8765, 0, 5'd17, 1'b1, 1'b0);
        alu(5'd18, 1'b1, 32'h0000_0018);
        repeat (4) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the RISC-V pipeline: the producer end of the register-file write port that the decode stage consumes (`reg_write`, `rd_select`, `rd_data`). It accepts retiring instructions over a valid/ready handshake, issues the data-memory read for loads, waits a variable number of cycles for the response, then byte/half-selects and extends the data. It drives exactly one register-file write per retiring instruction.

## Interface
- `WORD_SIZE`, 32: datapath width.
- `NUM_REGS`, 32: register count.
- `REG_SEL`, `$clog2(NUM_REGS)`: register select width.
- `ADDR_SIZE`, 10: data-memory word-address width.

- `clk` input 1: single clock; everything is on its rising edge.
- `rst` input 1: reset, synchronous and active-low.
- `in_valid` input 1: upstream holds a retiring instruction.
- `in_ready` output 1: stage can accept; combinational from state.
- `in_write_reg` input 1: instruction writes a register.
- `in_mem_read` input 1: instruction is a load.
- `in_func3` input 3: load width/sign code.
- `in_dest` input REG_SEL: destination register.
- `in_alu_result` input WORD_SIZE: ALU result, which is the byte address for loads.
- `dmem_req` output 1: one-cycle read request.
- `dmem_addr` output ADDR_SIZE: word address, `in_alu_result[ADDR_SIZE+1:2]` registered.
- `dmem_rdata` input WORD_SIZE: read data, valid with `dmem_rvalid`.
- `dmem_rvalid` input 1: read response strobe.
- `reg_write` output 1: register-file write enable, one-cycle pulse.
- `rd_select` output REG_SEL: write register.
- `rd_data` output WORD_SIZE: write data.
- `busy` output 1: high in LOAD_WAIT.
- `misalign` output 1: misaligned-load pulse. Present only with `WB_MISALIGN_TRAP_EN`.

## Operation
- States: IDLE and LOAD_WAIT.
- `in_ready` = (state == IDLE). An instruction is accepted when `in_valid && in_ready` at a clock edge.
- IDLE, accepted non-load:
  - Next cycle: `reg_write` = `in_write_reg && in_dest != 0`, `rd_select` = `in_dest`, `rd_data` = `in_alu_result`.
  - State stays IDLE.
- IDLE, accepted load:
  - Capture `in_func3`, `in_dest`, `in_write_reg` and `in_alu_result[1:0]`.
  - Next cycle: `dmem_req` = 1 and `dmem_addr` is valid.
  - Go to LOAD_WAIT.
- LOAD_WAIT: on `dmem_rvalid`, extract and extend the data, then write on the next cycle with the same x0 suppression. Return to IDLE on that same edge.
- `dmem_rvalid` is ignored in IDLE.
- Load extraction, with `lane` = captured addr[1:0]:
  - func3 000 LB: byte `lane`, sign-extended.
  - func3 100 LBU: byte `lane`, zero-extended.
  - func3 001 LH: half `addr[1]`, sign-extended.
  - func3 101 LHU: half `addr[1]`, zero-extended.
  - func3 010 and the unused codes 011, 110, 111: full word.
- x0 is never written: `reg_write` stays 0 when the destination is 0, even if `in_write_reg` = 1.
- `reg_write` and `dmem_req` deassert the cycle after they pulse unless a new event re-asserts them.
- `rd_select` and `rd_data` hold their last values when `reg_write` = 0.

## Timing
- Reset (`rst` = 0 at an edge):
  - State returns to IDLE.
  - `reg_write`, `dmem_req`, `busy` and `misalign` go to 0.
  - `rd_select`, `rd_data` and `dmem_addr` go to 0.
  - `in_ready` = 1 from the first cycle after reset.
- Non-load latency: accept at edge N, `reg_write` high in cycle N+1. Throughput is one instruction per cycle.
- Load latency:
  - Accept at edge N; `dmem_req` high in cycle N+1.
  - The first possible `dmem_rvalid` is sampled in cycle N+1 (zero-wait memory).
  - Response sampled at edge M: `reg_write` high in cycle M+1, and `in_ready` is high again in cycle M+1.
  - Zero-wait memory therefore gives a 2-cycle load with a 1-cycle bubble.
- Reset during LOAD_WAIT: the pending load is dropped with no write. A response arriving after reset is ignored.
- `in_valid` during LOAD_WAIT is not accepted; upstream must hold its data.

## Configuration
- `WB_MISALIGN_TRAP_EN` defined:
  - A load is misaligned when LH/LHU has addr[0] = 1, or when LW has addr[1:0] != 0.
  - An accepted misaligned load issues no `dmem_req`, performs no register write and stays in IDLE.
  - `misalign` pulses high in cycle N+1.
- `WB_MISALIGN_TRAP_EN` undefined:
  - No `misalign` port.
  - Misaligned loads proceed and ignore the low address bits as in the extraction rules.

## Test plan
- Reset, then a non-load with dest=5 and result 0x1234_5678: cycle N+1 shows `reg_write`=1, `rd_select`=5, `rd_data`=0x1234_5678. The same instruction with dest=0 gives `reg_write`=0.
- Three back-to-back non-loads: three consecutive `reg_write` pulses, with `in_ready` high throughout.
- LB from address 0x103 with memory word 0x80FF_7F01 and `rvalid` 3 cycles after the request: `dmem_addr`=0x040, `rd_data`=0xFFFF_FF80, `in_ready` low for 4 cycles. The same access as LBU gives 0x0000_0080.
- LH/LHU from address 0x102 with word 0x8001_0000: `rd_data` = 0xFFFF_8001 / 0x0000_8001. LW with `rvalid` in cycle N+1: write in N+2.
- `rst` low during LOAD_WAIT, then `dmem_rvalid` pulsed: no `reg_write`, state IDLE, `in_ready`=1.
- With `WB_MISALIGN_TRAP_EN`, LW at address 0x101: `misalign`=1 in N+1, no `dmem_req`, no write. Without the macro: request to word 0x040 and a full-word write.
